vote_tally_ranker: RTL and testbench
====================================

Name: vote_tally_ranker

Overview:
- Downstream consumer of the per-candidate vote counters produced by the voting machine's vote logger.
- On entry to result mode (mode 0->1), snapshots the four 8-bit counts and runs a 4-cycle sequential compare to find the winner, tie status and total.
- Then scans the candidates one at a time on a display bus with a programmable hold time.
- Drives the result/announcement path: seven-segment/LED driver and any external reporting.

Parameters:
HOLD_CYCLES, 100000000, clock cycles each candidate stays on the display bus in SHOW (minimum 1)
HOLD_W, 27, width of the hold counter (must satisfy 2^HOLD_W > HOLD_CYCLES)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
mode  input  1  0 = voting mode, 1 = result mode; synchronous to clock
valid_vote_casted  input  1  OR of all candidate valid-vote pulses; monitor only
cand1_vote  input  8  candidate 1 count from vote logger
cand2_vote  input  8  candidate 2 count
cand3_vote  input  8  candidate 3 count
cand4_vote  input  8  candidate 4 count
busy  output  1  high while in COMPARE
result_valid  output  1  winner/tie/total outputs are valid
winner_id  output  2  0..3 = candidate 1..4
winner_votes  output  8  winning count
tie  output  1  two or more candidates share the maximum
total_votes  output  10  sum of the four snapshotted counts
disp_cand  output  2  candidate currently on the display bus
disp_votes  output  8  snapshotted count of disp_cand
vote_in_result  output  1  sticky flag: valid_vote_casted seen while mode=1

Behaviour:
- Reset (synchronous, sampled on the clock edge):
  - State = IDLE.
  - All outputs = 0; mode_q = 0; snapshot registers = 0; hold counter = 0.
- Edge detection: mode_q registers mode; a rise is mode=1 and mode_q=0.
- States: IDLE, COMPARE, SHOW.
- IDLE:
  - On the edge that detects a rise (E0): snapshot cand1..4_vote into snap[0..3].
  - Also at E0: best=0, best_id=0, tie_r=0, sum=0, idx=0; go to COMPARE. busy=1 from E0.
- COMPARE (edges E1..E4 process idx 0..3):
  - If snap[idx] > best: best=snap[idx], best_id=idx, tie_r=0.
  - Else if snap[idx]==best and idx!=0: tie_r=1.
  - sum += snap[idx], zero-extended to 10 bits. Maximum sum is 1020, so no overflow is possible.
- COMPARE -> SHOW:
  - At E4: load winner_id, winner_votes, tie, total_votes; result_valid=1; busy=0.
  - Also at E4: disp_cand=0, disp_votes=snap[0], hold counter=0.
  - Latency: result_valid is high on the 5th rising edge counting the detect edge. Outputs are stable thereafter.
- SHOW:
  - Hold counter increments each cycle.
  - When it reaches HOLD_CYCLES-1: clear it, disp_cand increments modulo 4 (3 wraps to 0), disp_votes = snap[new disp_cand].
- Ties and all-zero counts:
  - Ties keep the lowest-numbered candidate as winner_id, with tie=1.
  - All counts zero: winner_id=0, winner_votes=0, tie=1, total=0.
- Leaving result mode (mode=0 in COMPARE or SHOW): on that edge, return to IDLE.
  - result_valid, busy, tie, winner_id, winner_votes, total_votes, disp_cand, disp_votes all -> 0.
  - An aborted COMPARE produces no result.
- Snapshot isolation: input count changes after E0 do not affect the current result.
- vote_in_result:
  - Set when valid_vote_casted=1 and mode=1 in any state.
  - Cleared only by reset; it is an audit flag.
  - Votes in voting mode (mode=0) never set it.
- Simultaneous reset and mode rise: reset wins, state IDLE. A rise is still detected on the next edge if mode is still 1 and mode_q was reset to 0.

Optional Feature:
- Macro: VOTE_RANK_RUNNER_UP_EN.
- Defined: adds outputs runner_up_id (2) and runner_up_votes (8), updated during COMPARE.
  - A strictly greater value demotes the old best to runner-up.
  - Otherwise a value greater than the current runner-up, or equal to best when tie, replaces the runner-up; the lowest index is kept on equality.
  - Valid with result_valid; reset/cleared to 0 with the other results.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- HOLD_CYCLES=4; counts 5,9,3,7; raise mode -> 5th edge result_valid=1, winner_id=1, winner_votes=9, tie=0, total_votes=24; disp_cand sequence 0,1,2,3,0 with each value held 4 cycles; disp_votes 5,9,3,7,5.
- Counts 8,8,2,8 -> winner_id=0, winner_votes=8, tie=1, total_votes=26.
- All counts 0 -> winner_id=0, winner_votes=0, tie=1, total_votes=0; counts 255 x4 -> total_votes=1020, tie=1.
- Drop mode to 0 two edges after the rise -> state IDLE and busy=0 on the next edge, result_valid never asserted; raise again with new counts -> fresh correct result.
- In SHOW, change cand2_vote 9->50 and pulse valid_vote_casted -> winner/disp values unchanged, vote_in_result=1 and stays 1 after mode=0 until reset.
- With VOTE_RANK_RUNNER_UP_EN and counts 5,9,3,7 -> runner_up_id=3, runner_up_votes=7; assert reset mid-SHOW -> all outputs 0 on that edge.

Source files
------------

// File: rtl/vote_tally_ranker.sv
// vote_tally_ranker
// Snapshots four candidate vote counts on entry to result mode, walks them in a
// four-cycle sequential compare to find winner, tie status and total, then
// scans the candidates on a display bus with a programmable hold time.
//
// Optional build macro: VOTE_RANK_RUNNER_UP_EN adds runner_up_id/runner_up_votes.
//
// Output handshake: result_valid is a level, not a pulse. It rises once the
// compare finishes, stays high while mode remains 1, and drops together with
// every result output on the edge that samples mode=0. There is no ready;
// consumers sample whenever result_valid is high.
module vote_tally_ranker #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mode,
  input  logic        valid_vote_casted,
  input  logic [7:0]  cand1_vote,
  input  logic [7:0]  cand2_vote,
  input  logic [7:0]  cand3_vote,
  input  logic [7:0]  cand4_vote,
  output logic        busy,
  output logic        result_valid,
  output logic [1:0]  winner_id,
  output logic [7:0]  winner_votes,
  output logic        tie,
  output logic [9:0]  total_votes,
  output logic [1:0]  disp_cand,
  output logic [7:0]  disp_votes,
  output logic        vote_in_result,
`ifdef VOTE_RANK_RUNNER_UP_EN
  output logic [1:0]  runner_up_id,
  output logic [7:0]  runner_up_votes,
`endif
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPARE = 2'd1;
  localparam logic [1:0] S_SHOW    = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        state;
  logic              mode_q;
  logic              mode_rise;
  logic              leave;
  logic [7:0]        snap [4];
  logic [7:0]        best;
  logic [1:0]        best_id;
  logic              tie_r;
  logic [9:0]        sum;
  logic [1:0]        idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        cur_v;
  logic [7:0]        nxt_best;
  logic [1:0]        nxt_best_id;
  logic              nxt_tie;
  logic [9:0]        nxt_sum;
  logic [1:0]        next_disp;
`ifdef VOTE_RANK_RUNNER_UP_EN
  logic [7:0]        ru;
  logic [1:0]        ru_id;
  logic [7:0]        nxt_ru;
  logic [1:0]        nxt_ru_id;
`endif

  assign fsm_state = state;
  assign busy      = (state == S_COMPARE);
  assign mode_rise = mode && !mode_q;
  // Dropping mode aborts a compare or ends the display scan.
  assign leave     = (state != S_IDLE) && !mode;
  assign cur_v     = snap[idx];
  assign next_disp = disp_cand + 2'd1;

  // One compare step on the snapshot entry selected by idx.
  always_comb begin
    nxt_best    = best;
    nxt_best_id = best_id;
    nxt_tie     = tie_r;
    nxt_sum     = sum + {2'b00, cur_v};
    if (cur_v > best) begin
      nxt_best    = cur_v;
      nxt_best_id = idx;
      nxt_tie     = 1'b0;
    end else if ((cur_v == best) && (idx != 2'd0)) begin
      nxt_tie = 1'b1;
    end
  end

`ifdef VOTE_RANK_RUNNER_UP_EN
  // Runner-up tracking: a new best demotes the old one; otherwise only a
  // strictly larger value replaces it, so the lowest index wins on equality.
  always_comb begin
    nxt_ru    = ru;
    nxt_ru_id = ru_id;
    if (cur_v > best) begin
      nxt_ru    = best;
      nxt_ru_id = best_id;
    end else if (cur_v > ru) begin
      nxt_ru    = cur_v;
      nxt_ru_id = idx;
    end
  end
`endif

  // Mode edge detector and the sticky audit flag for votes seen in result mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q         <= 1'b0;
      vote_in_result <= 1'b0;
    end else begin
      mode_q <= mode;
      if (valid_vote_casted && mode) begin
        vote_in_result <= 1'b1;
      end
    end
  end

  // Main sequencer: IDLE -> COMPARE (4 steps) -> SHOW, back to IDLE on mode=0.
  always_ff @(posedge clock) begin
    if (reset || leave) begin
      state        <= S_IDLE;
      result_valid <= 1'b0;
      winner_id    <= 2'd0;
      winner_votes <= 8'd0;
      tie          <= 1'b0;
      total_votes  <= 10'd0;
      disp_cand    <= 2'd0;
      disp_votes   <= 8'd0;
      hold_cnt     <= '0;
      best         <= 8'd0;
      best_id      <= 2'd0;
      tie_r        <= 1'b0;
      sum          <= 10'd0;
      idx          <= 2'd0;
`ifdef VOTE_RANK_RUNNER_UP_EN
      ru              <= 8'd0;
      ru_id           <= 2'd0;
      runner_up_id    <= 2'd0;
      runner_up_votes <= 8'd0;
`endif
      if (reset) begin
        for (int i = 0; i < 4; i++) snap[i] <= 8'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (mode_rise) begin
            snap[0] <= cand1_vote;
            snap[1] <= cand2_vote;
            snap[2] <= cand3_vote;
            snap[3] <= cand4_vote;
            best    <= 8'd0;
            best_id <= 2'd0;
            tie_r   <= 1'b0;
            sum     <= 10'd0;
            idx     <= 2'd0;
`ifdef VOTE_RANK_RUNNER_UP_EN
            ru      <= 8'd0;
            ru_id   <= 2'd0;
`endif
            state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          best    <= nxt_best;
          best_id <= nxt_best_id;
          tie_r   <= nxt_tie;
          sum     <= nxt_sum;
          idx     <= idx + 2'd1;
`ifdef VOTE_RANK_RUNNER_UP_EN
          ru      <= nxt_ru;
          ru_id   <= nxt_ru_id;
`endif
          if (idx == 2'd3) begin
            winner_id    <= nxt_best_id;
            winner_votes <= nxt_best;
            tie          <= nxt_tie;
            total_votes  <= nxt_sum;
            result_valid <= 1'b1;
            disp_cand    <= 2'd0;
            disp_votes   <= snap[0];
            hold_cnt     <= '0;
`ifdef VOTE_RANK_RUNNER_UP_EN
            runner_up_id    <= nxt_ru_id;
            runner_up_votes <= nxt_ru;
`endif
            state        <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt   <= '0;
            disp_cand  <= next_disp;
            disp_votes <= snap[next_disp];
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_ranker.sv
// tb_vote_tally_ranker
// Randomized and directed stimulus against a behavioural model of the
// winner/tie/total/display rules. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_vote_tally_ranker;

  localparam int HOLD = 4;
  localparam int HW   = 3;

  logic        clock;
  logic        reset;
  logic        mode;
  logic        valid_vote_casted;
  logic [7:0]  cand1_vote, cand2_vote, cand3_vote, cand4_vote;
  logic        busy, result_valid, tie, vote_in_result;
  logic [1:0]  winner_id, disp_cand, fsm_state;
  logic [7:0]  winner_votes, disp_votes;
  logic [9:0]  total_votes;
`ifdef VOTE_RANK_RUNNER_UP_EN
  logic [1:0]  runner_up_id;
  logic [7:0]  runner_up_votes;
`endif

  vote_tally_ranker #(.HOLD_CYCLES(HOLD), .HOLD_W(HW)) dut (
    .clock             (clock),
    .reset             (reset),
    .mode              (mode),
    .valid_vote_casted (valid_vote_casted),
    .cand1_vote        (cand1_vote),
    .cand2_vote        (cand2_vote),
    .cand3_vote        (cand3_vote),
    .cand4_vote        (cand4_vote),
    .busy              (busy),
    .result_valid      (result_valid),
    .winner_id         (winner_id),
    .winner_votes      (winner_votes),
    .tie               (tie),
    .total_votes       (total_votes),
    .disp_cand         (disp_cand),
    .disp_votes        (disp_votes),
    .vote_in_result    (vote_in_result),
`ifdef VOTE_RANK_RUNNER_UP_EN
    .runner_up_id      (runner_up_id),
    .runner_up_votes   (runner_up_votes),
`endif
    .fsm_state         (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] cnt [4];
  int m_win, m_wvotes, m_tie, m_total, m_ru_id, m_ru_votes;
  int show_k;
  logic exp_vir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Winner = first candidate holding the maximum; tie if the maximum occurs
  // more than once; runner-up = largest nonzero count among the others.
  task automatic model_compute();
    int mx, n;
    mx = 0; n = 0; m_total = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(cnt[i]) > mx) mx = int'(cnt[i]);
      m_total += int'(cnt[i]);
    end
    m_win = -1;
    for (int i = 0; i < 4; i++) begin
      if (int'(cnt[i]) == mx) begin
        n++;
        if (m_win < 0) m_win = i;
      end
    end
    m_wvotes = mx;
    m_tie    = (n >= 2) ? 1 : 0;
    m_ru_id = 0; m_ru_votes = 0;
    for (int i = 0; i < 4; i++) begin
      if (i != m_win && int'(cnt[i]) > m_ru_votes) begin
        m_ru_votes = int'(cnt[i]);
        m_ru_id    = i;
      end
    end
  endtask

  task automatic check_results();
    check("result_valid", result_valid, 1);
    check("busy_show", busy, 0);
    check("winner_id", winner_id, m_win);
    check("winner_votes", winner_votes, m_wvotes);
    check("tie", tie, m_tie);
    check("total_votes", total_votes, m_total);
`ifdef VOTE_RANK_RUNNER_UP_EN
    check("runner_up_id", runner_up_id, m_ru_id);
    check("runner_up_votes", runner_up_votes, m_ru_votes);
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"}, fsm_state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_win"}, winner_id, 0);
    check({tag, "_wv"}, winner_votes, 0);
    check({tag, "_tie"}, tie, 0);
    check({tag, "_total"}, total_votes, 0);
    check({tag, "_dcand"}, disp_cand, 0);
    check({tag, "_dvotes"}, disp_votes, 0);
`ifdef VOTE_RANK_RUNNER_UP_EN
    check({tag, "_ru_id"}, runner_up_id, 0);
    check({tag, "_ru_v"}, runner_up_votes, 0);
`endif
  endtask

  // driver: raise mode from IDLE and walk through the compare latency
  task automatic run_result(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input bit scramble);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    cand1_vote = a; cand2_vote = b; cand3_vote = c; cand4_vote = d;
    mode = 1'b1;
    model_compute();
    for (int e = 0; e < 4; e++) begin
      @(negedge clock);
      check("busy_cmp", busy, 1);
      check("rv_early", result_valid, 0);
      if (scramble) begin
        cand1_vote = 8'($urandom_range(0, 255));
        cand2_vote = 8'($urandom_range(0, 255));
        cand3_vote = 8'($urandom_range(0, 255));
        cand4_vote = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clock);
    check_results();
    show_k = 0;
  endtask

  // Display scan: each candidate held HOLD cycles, wrapping 3 -> 0.
  task automatic show_check(input int ncycles);
    int ec;
    for (int i = 0; i < ncycles; i++) begin
      ec = (show_k / HOLD) % 4;
      check("disp_cand", disp_cand, ec);
      check("disp_votes", disp_votes, cnt[ec]);
      @(negedge clock);
      show_k++;
    end
  endtask

  task automatic drop_mode();
    mode = 1'b0;
    @(negedge clock);
    check_cleared("drop");
    check("vir_after_drop", vote_in_result, exp_vir);
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; valid_vote_casted = 1'b0;
    cand1_vote = 8'd0; cand2_vote = 8'd0; cand3_vote = 8'd0; cand4_vote = 8'd0;
    exp_vir = 1'b0;
    show_k = 0;
    repeat (2) @(negedge clock);
    check_cleared("reset");
    check("reset_vir", vote_in_result, 0);
    reset = 1'b0;
    @(negedge clock);

    // votes in voting mode never set the audit flag
    valid_vote_casted = 1'b1;
    @(negedge clock);
    valid_vote_casted = 1'b0;
    check("vir_voting_mode", vote_in_result, 0);

    // main directed case with full display scan
    run_result(8'd5, 8'd9, 8'd3, 8'd7, 1'b0);
    show_check(22);
    // late input change and vote in result mode must not disturb the result
    cand2_vote = 8'd50;
    valid_vote_casted = 1'b1;
    exp_vir = 1'b1;
    @(negedge clock);
    show_k++;
    valid_vote_casted = 1'b0;
    check("vir_set", vote_in_result, 1);
    show_check(6);
    check_results();
    drop_mode();
    repeat (3) @(negedge clock);
    check("vir_sticky", vote_in_result, 1);

    // ties and boundary counts
    run_result(8'd8, 8'd8, 8'd2, 8'd8, 1'b0);
    show_check(5);
    drop_mode();
    run_result(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    show_check(5);
    drop_mode();
    run_result(8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
    show_check(5);
    drop_mode();

    // abort two edges after the rise
    cand1_vote = 8'd1; cand2_vote = 8'd2; cand3_vote = 8'd3; cand4_vote = 8'd4;
    mode = 1'b1;
    @(negedge clock);
    check("abort_busy_e0", busy, 1);
    @(negedge clock);
    mode = 1'b0;
    @(negedge clock);
    check_cleared("abort");
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("abort_no_rv", result_valid, 0);
    end
    run_result(8'd12, 8'd40, 8'd40, 8'd3, 1'b0);
    show_check(5);
    drop_mode();

    // randomized runs with input churn after the snapshot
    for (int r = 0; r < 25; r++) begin
      logic [7:0] v [4];
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 3 : 255;
      for (int i = 0; i < 4; i++) v[i] = 8'($urandom_range(0, hi));
      run_result(v[0], v[1], v[2], v[3], 1'b1);
      show_check($urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) begin
        valid_vote_casted = 1'b1;
        exp_vir = 1'b1;
        @(negedge clock);
        show_k++;
        valid_vote_casted = 1'b0;
        show_check(2);
      end
      check_results();
      check("vir_rand", vote_in_result, exp_vir);
      drop_mode();
    end

    // reset in the middle of SHOW clears everything on that edge
    run_result(8'd5, 8'd9, 8'd3, 8'd7, 1'b0);
    show_check(6);
    reset = 1'b1;
    mode = 1'b0;
    @(negedge clock);
    exp_vir = 1'b0;
    check_cleared("rst_show");
    check("rst_show_vir", vote_in_result, 0);

    // simultaneous reset and mode rise: reset wins, rise seen next edge
    mode = 1'b1;
    @(negedge clock);
    check("simul_state", fsm_state, 0);
    check("simul_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);
    check("simul_rise_busy", busy, 1);
    mode = 1'b0;
    @(negedge clock);
    check_cleared("simul_drop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
